data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter: RAM_AW, default 10, word-address width, so the RAM holds 2^RAM_AW 32-bit words.
REQ-002 Parameter: TXQ_AW, default 3, TX FIFO address width, so the FIFO holds 8 entries.
REQ-003 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port: rst, input, 1, synchronous active-high reset.
REQ-005 Port: ce, input, 1, access enable from the CPU MEM stage.
REQ-006 Port: we, input, 1, write when 1, read when 0.
REQ-007 Port: sel, input, 4, byte lanes; sel[3]=data[31:24] … sel[0]=data[7:0].
REQ-008 Port: addr, input, 32, byte address.
REQ-009 Port: data_i, input, 32, write data.
REQ-010 Port: data_o, output, 32, read data.
REQ-011 Port: tx_data, output, 8, head byte of the TX FIFO.
REQ-012 Port: tx_valid, output, 1, FIFO non-empty.
REQ-013 Port: tx_ready, input, 1, sink accepts the byte when tx_valid&tx_ready.
REQ-014 Port: irq_o, output, 1, sticky timer-match interrupt.

Function
REQ-015 Decode: addr[31:28]==0 is RAM (word index addr[RAM_AW+1:2]); addr[31:28]==1 is MMIO (register addr[4:2]); all other addresses are unmapped.
REQ-016 Reads are combinational: data_o = selected word when ce=1 and we=0; otherwise data_o=0. Unmapped reads and reserved MMIO registers return 0.
REQ-017 RAM write: on the clock edge with ce&we, each byte lane with sel[i]=1 is updated; unselected lanes keep their value.
REQ-018 A read in the cycle after a write returns the new data; there is no extra latency.
REQ-019 MMIO reg 0, TXDATA: a write with sel!=0 pushes data_i[7:0]; reads return 0.
REQ-020 MMIO reg 1, STATUS (read-only): bit0=empty, bit1=full, bit2=overflow (sticky), bits[7:4]=count (0..8).
REQ-021 MMIO reg 2, CYCLE (read-only): 32-bit free-running counter, +1 every cycle, wraps 0xFFFFFFFF→0.
REQ-022 MMIO reg 3, CMP (read/write): the lanes selected by sel are written.
REQ-023 MMIO reg 4, IRQCLR: any write clears irq_o and overflow; reads return {30'b0, overflow, irq_o}.
REQ-024 irq_o sets on the edge after CYCLE==CMP and holds until IRQCLR. If set and clear coincide, set wins.
REQ-025 FIFO pop: occurs on the edge where tx_valid&tx_ready. tx_data is valid whenever tx_valid=1 and stays stable until popped.
REQ-026 FIFO push when full with no pop in the same cycle: the byte is dropped, overflow sets, and the FIFO is unchanged.
REQ-027 Push and pop in the same cycle: both occur and count is unchanged. This holds when full too (the push is accepted, no overflow).
REQ-028 Pointers wrap modulo 2^TXQ_AW. count is tracked separately so that full and empty are unambiguous.
REQ-029 Writes to unmapped addresses or reserved MMIO registers have no effect.

Reset
REQ-030 While rst=1, on each edge: CYCLE=0, CMP=0xFFFFFFFF, irq_o=0, overflow=0, and FIFO pointers and count are 0.
REQ-031 Consequently tx_valid=0 and tx_data=0 after reset. data_o follows REQ-016.
REQ-032 RAM contents are not reset.
REQ-033 A reset asserted mid-operation (FIFO partly full, irq set) discards all queued bytes.
REQ-034 CPU accesses and tx_ready are ignored while rst=1.

Structure
REQ-035 Address-map constants (region nibbles, MMIO register indices, STATUS bit positions) are placed in the shared defines file alongside RegBus and related definitions.
REQ-036 One sub-module, txq_fifo (parameterised width 8, depth 2^TXQ_AW, push/pop/full/empty/count), is instantiated once.
REQ-037 The RAM array, decode, CYCLE/CMP/irq logic and the read mux stay in data_mem.

Verification
REQ-038 Byte-lane write: write 0x11223344 to 0x0000_0010 with sel=1111, then write 0x0000AA00 with sel=0010 → a read of 0x10 returns 0x1122AA44.
REQ-039 Read gating: a read of 0x0000_0010 with ce=0 → data_o=0; a read of 0x2000_0000 with ce=1 → data_o=0.
REQ-040 FIFO fill: tx_ready=0, push 0x41..0x49 (9 bytes) → STATUS=0x0000_0086 (count 8, full, overflow). Raise tx_ready → tx_data sequence 0x41..0x48, then tx_valid=0 and STATUS=0x0000_0005.
REQ-041 Full push+pop: with the FIFO full and tx_ready=1, push 0x5A in the same cycle → count stays 8, no overflow, and 0x5A is the last byte drained.
REQ-042 Timer: after reset, write CMP=20 → irq_o rises on the edge after CYCLE==20 and stays high. An IRQCLR write clears it. A second match occurs only after CYCLE wraps.
REQ-043 Reset mid-operation: with 3 bytes queued and irq_o=1, pulse rst for 1 cycle → tx_valid=0, irq_o=0, STATUS=0x0000_0001, CYCLE restarts at 0, and a previously written RAM word is still readable unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared address map and helpers for the data memory slice.
//   - Region nibbles (addr[31:28]) selecting RAM, MMIO or nothing.
//   - MMIO register indices (addr[4:2]).
//   - STATUS register bit positions.
//   - decode_space(): region nibble -> address space.
//   - merge_lanes(): byte-lane merge of a write into an existing word.
package data_mem_pkg;

    localparam logic [3:0] RGN_RAM  = 4'h0;
    localparam logic [3:0] RGN_MMIO = 4'h1;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CYCLE  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_IRQCLR = 3'd4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    typedef enum logic [1:0] {
        SPACE_RAM,
        SPACE_MMIO,
        SPACE_NONE
    } space_e;

    function automatic space_e decode_space(input logic [3:0] region);
        case (region)
            RGN_RAM:  return SPACE_RAM;
            RGN_MMIO: return SPACE_MMIO;
            default:  return SPACE_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/txq_fifo.sv
// txq_fifo: small synchronous FIFO feeding the TX byte sink.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   push, push_data  - enqueue request and data (ignored when full unless popping)
//   pop              - dequeue request (ignored when empty)
//   head             - oldest entry, forced to 0 while empty
//   full, empty      - occupancy flags
//   count            - number of entries, 0..2^AW
module txq_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A push into a full queue is still accepted when a pop frees a slot
    // on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/data_mem.sv
// data_mem: CPU data memory with a small MMIO block.
//   RAM  : 2^RAM_AW words at region 0, byte-lane writes, combinational read.
//   MMIO : region 1 - TXDATA push, STATUS, free-running CYCLE, CMP, IRQCLR.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   ce, we, sel, addr   - CPU access enable, write strobe, byte lanes, byte address
//   data_i, data_o      - write data, combinational read data (0 when not reading)
//   tx_data, tx_valid   - head of the TX queue and its non-empty flag
//   tx_ready            - sink accepts the head byte this cycle
//   irq_o               - sticky CYCLE==CMP interrupt
module data_mem
    import data_mem_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int TXQ_AW = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq_o
);

    logic [31:0] ram [2**RAM_AW];

    space_e            space;
    logic [2:0]        reg_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_en;
    logic              ram_wr;
    logic              mmio_wr;
    logic              push;
    logic              pop;
    logic              cmp_wr;
    logic              irqclr_wr;
    logic              overflow_set;
    logic              cycle_match;

    logic [31:0]       cycle;
    logic [31:0]       cmp;
    logic              overflow;
    logic [31:0]       status_word;

    logic              txq_full;
    logic              txq_empty;
    logic [TXQ_AW:0]   txq_count;

    // Address bits that neither the RAM index nor the MMIO decode look at.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{addr[27:RAM_AW+2], addr[1:0]};

    assign space   = decode_space(addr[31:28]);
    assign reg_idx = addr[4:2];
    assign ram_idx = addr[RAM_AW+1:2];

    // CPU writes are ignored while in reset.
    assign wr_en     = ce && we && !rst;
    assign ram_wr    = wr_en && (space == SPACE_RAM);
    assign mmio_wr   = wr_en && (space == SPACE_MMIO);
    assign push      = mmio_wr && (reg_idx == REG_TXDATA) && (sel != 4'b0000);
    assign cmp_wr    = mmio_wr && (reg_idx == REG_CMP);
    assign irqclr_wr = mmio_wr && (reg_idx == REG_IRQCLR);
    assign pop       = tx_valid && tx_ready && !rst;

    // A push only drops its byte when nothing leaves the queue on that edge.
    assign overflow_set = push && txq_full && !pop;
    assign cycle_match  = (cycle == cmp);

    txq_fifo #(
        .WIDTH(8),
        .AW   (TXQ_AW)
    ) u_txq (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(data_i[7:0]),
        .pop      (pop),
        .head     (tx_data),
        .full     (txq_full),
        .empty    (txq_empty),
        .count    (txq_count)
    );

    assign tx_valid = !txq_empty;

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    ram[ram_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle    <= '0;
            cmp      <= 32'hFFFF_FFFF;
            irq_o    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;
            if (cmp_wr) begin
                cmp <= merge_lanes(cmp, data_i, sel);
            end
            // A match on the same edge as a clear keeps the interrupt set.
            if (cycle_match) begin
                irq_o <= 1'b1;
            end else if (irqclr_wr) begin
                irq_o <= 1'b0;
            end
            if (irqclr_wr) begin
                overflow <= 1'b0;
            end else if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        status_word                           = '0;
        status_word[ST_EMPTY]                 = txq_empty;
        status_word[ST_FULL]                  = txq_full;
        status_word[ST_OVF]                   = overflow;
        status_word[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(txq_count);
    end

    always_comb begin
        data_o = '0;
        if (ce && !we) begin
            case (space)
                SPACE_RAM: data_o = ram[ram_idx];
                SPACE_MMIO: begin
                    case (reg_idx)
                        REG_STATUS: data_o = status_word;
                        REG_CYCLE:  data_o = cycle;
                        REG_CMP:    data_o = cmp;
                        REG_IRQCLR: data_o = {30'b0, overflow, irq_o};
                        default:    data_o = '0;
                    endcase
                end
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed bench for data_mem with a behavioural reference model
// (word array, byte queue, plain counters) checked on every falling edge, plus
// hand-computed literal checks on the key scenarios.
module tb_data_mem;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h1000_0008;
    localparam logic [31:0] A_CMP    = 32'h1000_000C;
    localparam logic [31:0] A_IRQCLR = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem #(.RAM_AW(10), .TXQ_AW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .we      (we),
        .sel     (sel),
        .addr    (addr),
        .data_i  (data_i),
        .data_o  (data_o),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .irq_o   (irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ram [1024];
    bit          m_known [1024];
    logic [31:0] m_cyc;
    logic [31:0] m_cmp;
    bit          m_irq;
    bit          m_ovf;
    logic [7:0]  m_q [$];
    bit          model_ready = 0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int n;
        n = m_q.size();
        s = '0;
        s[7:4] = 4'(n);
        s[0] = (n == 0);
        s[1] = (n == 8);
        s[2] = m_ovf;
        return s;
    endfunction

    initial begin
        bit wr, in_mmio, in_ram, do_pop, do_push, do_clr, match, was_full;
        logic [2:0] r;
        int idx;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cyc = 0;
                m_cmp = 32'hFFFF_FFFF;
                m_irq = 0;
                m_ovf = 0;
                m_q.delete();
            end else begin
                wr       = ce && we;
                in_ram   = (addr[31:28] == 4'h0);
                in_mmio  = (addr[31:28] == 4'h1);
                r        = addr[4:2];
                idx      = int'(addr[11:2]);
                match    = (m_cyc == m_cmp);
                was_full = (m_q.size() == 8);
                do_pop   = (m_q.size() != 0) && tx_ready;
                do_push  = wr && in_mmio && (r == 3'd0) && (sel != 4'b0000);
                do_clr   = wr && in_mmio && (r == 3'd4);
                if (do_pop) void'(m_q.pop_front());
                if (do_clr) m_ovf = 0;
                if (do_push) begin
                    if (was_full && !do_pop) m_ovf = 1;
                    else m_q.push_back(data_i[7:0]);
                end
                if (match) m_irq = 1;
                else if (do_clr) m_irq = 0;
                if (wr && in_mmio && r == 3'd3)
                    for (int i = 0; i < 4; i++)
                        if (sel[i]) m_cmp[8*i +: 8] = data_i[8*i +: 8];
                if (wr && in_ram) begin
                    for (int i = 0; i < 4; i++)
                        if (sel[i]) m_ram[idx][8*i +: 8] = data_i[8*i +: 8];
                    m_known[idx] = 1;
                end
                m_cyc = m_cyc + 32'd1;
            end
            model_ready = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [31:0] exp_d;
        bit exp_ok;
        forever begin
            @(negedge clk);
            if (model_ready) begin
                chk("model_tx_valid", {31'h0, tx_valid}, {31'h0, (m_q.size() != 0)});
                chk("model_tx_data", {24'h0, tx_data}, {24'h0, (m_q.size() != 0) ? m_q[0] : 8'h00});
                chk("model_irq", {31'h0, irq_o}, {31'h0, m_irq});
                exp_ok = 1;
                exp_d  = '0;
                if (ce && !we) begin
                    if (addr[31:28] == 4'h0) begin
                        if (m_known[addr[11:2]]) exp_d = m_ram[addr[11:2]];
                        else exp_ok = 0;
                    end else if (addr[31:28] == 4'h1) begin
                        case (addr[4:2])
                            3'd1:    exp_d = m_status();
                            3'd2:    exp_d = m_cyc;
                            3'd3:    exp_d = m_cmp;
                            3'd4:    exp_d = {30'h0, m_ovf, m_irq};
                            default: exp_d = '0;
                        endcase
                    end
                end
                if (exp_ok) chk("model_data_o", data_o, exp_d);
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1; we = 1; addr = a; data_i = d; sel = s;
        @(posedge clk);
        #1;
        ce = 0; we = 0; sel = 4'h0;
    endtask

    task automatic cpu_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        ce = 1; we = 0; addr = a; sel = 4'hF;
        @(negedge clk);
        chk(name, data_o, exp);
        @(posedge clk);
        #1;
        ce = 0;
    endtask

    task automatic read_val(input logic [31:0] a, output logic [31:0] v);
        ce = 1; we = 0; addr = a; sel = 4'hF;
        @(negedge clk);
        v = data_o;
        @(posedge clk);
        #1;
        ce = 0;
    endtask

    task automatic drain_check(input string name, input logic [7:0] exp_bytes [8]);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({name, "_valid"}, {31'h0, tx_valid}, 32'h1);
            chk({name, "_byte"}, {24'h0, tx_data}, {24'h0, exp_bytes[i]});
            @(posedge clk);
            #1;
        end
        tx_ready = 0;
        chk({name, "_empty"}, {31'h0, tx_valid}, 32'h0);
    endtask

    task automatic wait_irq(input string name, input int budget, output bit found);
        found = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (irq_o) begin
                found = 1;
                break;
            end
        end
        chk(name, {31'h0, found}, 32'h1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] c;
        logic [7:0]  seq [8];
        bit found;

        rst = 1; ce = 0; we = 0; sel = 4'h0; addr = '0; data_i = '0; tx_ready = 0;
        tick(2);
        rst = 0;

        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        cpu_read("rst_cycle", A_CYCLE, 32'h0);
        cpu_read("rst_status", A_STATUS, 32'h1);
        cpu_read("rst_cmp", A_CMP, 32'hFFFF_FFFF);

        // Timer: CMP=20, irq rises on the edge after CYCLE==20, so CYCLE reads 21.
        cpu_write(A_CMP, 32'd20, 4'hF);
        ce = 1; we = 0; addr = A_CYCLE; sel = 4'hF;
        wait_irq("irq_rise_found", 60, found);
        chk("irq_rise_cycle", data_o, 32'd21);
        @(posedge clk); #1;
        ce = 0;
        tick(5);
        chk("irq_sticky", {31'h0, irq_o}, 32'h1);
        cpu_write(A_IRQCLR, 32'h0, 4'h1);
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);
        tick(30);
        chk("irq_no_rematch", {31'h0, irq_o}, 32'h0);

        cpu_write(A_CMP, 32'h00AB_0000, 4'b0100);
        cpu_read("cmp_lane", A_CMP, 32'h00AB_0014);

        // Set and clear on the same edge: set wins, the held clear drops it next edge.
        read_val(A_CYCLE, c);
        cpu_write(A_CMP, c + 32'd8, 4'hF);
        ce = 1; we = 1; addr = A_IRQCLR; sel = 4'h1; data_i = '0;
        wait_irq("setwin_found", 20, found);
        @(negedge clk);
        chk("setwin_then_clear", {31'h0, irq_o}, 32'h0);
        @(posedge clk); #1;
        ce = 0; we = 0; sel = 4'h0;

        // RAM byte lanes, read-after-write, gating, unmapped/reserved accesses.
        cpu_write(32'h0000_0010, 32'h1122_3344, 4'b1111);
        cpu_write(32'h0000_0010, 32'h0000_AA00, 4'b0010);
        cpu_read("byte_lane", 32'h0000_0010, 32'h1122_AA44);
        cpu_write(32'h0000_0014, 32'hCAFE_F00D, 4'hF);
        cpu_read("raw_next_cycle", 32'h0000_0014, 32'hCAFE_F00D);
        ce = 0; we = 0; addr = 32'h0000_0010;
        @(negedge clk);
        chk("gate_ce0", data_o, 32'h0);
        @(posedge clk); #1;
        cpu_read("unmapped_read", 32'h2000_0000, 32'h0);
        cpu_write(32'h2000_0010, 32'hFFFF_FFFF, 4'hF);
        cpu_write(32'h1000_0014, 32'hFFFF_FFFF, 4'hF);
        cpu_read("unmapped_wr_noeffect", 32'h0000_0010, 32'h1122_AA44);
        cpu_read("reserved_read", 32'h1000_0014, 32'h0);

        // FIFO fill with overflow, then drain.
        for (int i = 0; i < 9; i++) cpu_write(A_TXDATA, 32'h41 + 32'(i), 4'b0001);
        cpu_read("fifo_full_status", A_STATUS, 32'h0000_0086);
        cpu_read("txdata_read", A_TXDATA, 32'h0);
        cpu_read("irqclr_read", A_IRQCLR, 32'h2);
        for (int i = 0; i < 8; i++) seq[i] = 8'h41 + 8'(i);
        drain_check("drain1", seq);
        cpu_read("drain_status", A_STATUS, 32'h0000_0005);
        cpu_write(A_IRQCLR, 32'h0, 4'h1);
        cpu_read("ovf_cleared", A_STATUS, 32'h1);
        cpu_write(A_TXDATA, 32'h99, 4'h0);
        cpu_read("sel0_no_push", A_STATUS, 32'h1);

        // Full queue: push and pop on the same edge.
        for (int i = 0; i < 8; i++) cpu_write(A_TXDATA, 32'h61 + 32'(i), 4'b0001);
        tx_ready = 1;
        cpu_write(A_TXDATA, 32'h5A, 4'b0001);
        tx_ready = 0;
        cpu_read("fullpp_status", A_STATUS, 32'h0000_0082);
        for (int i = 0; i < 7; i++) seq[i] = 8'h62 + 8'(i);
        seq[7] = 8'h5A;
        drain_check("drain2", seq);

        // Reset mid-operation.
        cpu_write(32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        for (int i = 0; i < 3; i++) cpu_write(A_TXDATA, 32'h31 + 32'(i), 4'b0001);
        read_val(A_CYCLE, c);
        cpu_write(A_CMP, c + 32'd4, 4'hF);
        wait_irq("pre_rst_irq", 20, found);
        @(posedge clk); #1;
        cpu_read("pre_rst_status", A_STATUS, 32'h0000_0030);
        rst = 1; ce = 1; we = 1; addr = 32'h0000_0040; data_i = 32'h0; sel = 4'hF; tx_ready = 1;
        @(posedge clk); #1;
        rst = 0; ce = 0; we = 0; sel = 4'h0; tx_ready = 0;
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("mid_rst_irq", {31'h0, irq_o}, 32'h0);
        cpu_read("mid_rst_cycle", A_CYCLE, 32'h0);
        cpu_read("mid_rst_status", A_STATUS, 32'h1);
        cpu_read("ram_survives", 32'h0000_0040, 32'hDEAD_BEEF);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: sequence did not finish, got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
